// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_re_i,
  input  logic             id_rs2_re_i,
  input  logic             ex_jump_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             hold_ex_mem_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             bubble_mem_wb_o,
  output logic             jump_o,
  output logic [31:0]      jump_addr_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // wait_cnt never exceeds MEM_TIMEOUT-1
  localparam int WC_W = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;

  logic load_use;
  logic mem_released;
  logic hold_all;
  logic bubble;
  logic do_jump;
  logic do_load_use;
  logic timeout_evt;

  // A dropped request while waiting is a protocol error and counts as completion
  assign mem_released = mem_ready_i | ~mem_req_i;

  assign load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
                    ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
                     (id_rs2_re_i && (id_rs2_i == ex_rd_i)));

  // Hazard resolution: outstanding memory wait first, then new mem stall, jump, load-use
  always_comb begin
    hold_all    = 1'b0;
    bubble      = 1'b0;
    do_jump     = 1'b0;
    do_load_use = 1'b0;
    timeout_evt = 1'b0;
    state_d     = ST_RUN;
    wait_cnt_d  = '0;
    if ((state_q == ST_MEM_WAIT) && !mem_released) begin
      if (wait_cnt_q == WC_LAST) begin
        // Give up on the access: let the pipe move and squash the MEM result
        bubble      = 1'b1;
        timeout_evt = 1'b1;
      end else begin
        hold_all   = 1'b1;
        bubble     = 1'b1;
        state_d    = ST_MEM_WAIT;
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else if (mem_req_i && !mem_ready_i) begin
      hold_all   = 1'b1;
      bubble     = 1'b1;
      state_d    = ST_MEM_WAIT;
      wait_cnt_d = WC_ONE;
    end else if (ex_jump_i) begin
      // A jump squashes the younger instructions, so any load-use stall is moot
      do_jump = 1'b1;
    end else if (load_use) begin
      do_load_use = 1'b1;
    end
  end

  // Pipeline controls act in the same cycle; all of them are quiet during reset
  always_comb begin
    hold_pc_o       = rst_n & (hold_all | do_load_use);
    hold_if_id_o    = rst_n & (hold_all | do_load_use);
    hold_id_ex_o    = rst_n & hold_all;
    hold_ex_mem_o   = rst_n & hold_all;
    flush_if_id_o   = rst_n & do_jump;
    flush_id_ex_o   = rst_n & (do_jump | do_load_use);
    bubble_mem_wb_o = rst_n & bubble;
    jump_o          = rst_n & do_jump;
    jump_addr_o     = rst_n ? ex_jump_addr_i : 32'd0;
  end

  // Sequencer state, wait counter and the registered timeout pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_o <= timeout_evt;
    end
  end

  // Saturating performance counters for stalled and redirected cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hold_pc_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (jump_o && (flush_cnt_o != {CNT_W{1'b1}}))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 5;
  localparam int SAT         = (1 << CNT_W) - 1;

  // Output bundle: {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex, bubble, jump}
  localparam logic [7:0] O_NONE = 8'h00;
  localparam logic [7:0] O_MEM  = 8'hF2;
  localparam logic [7:0] O_JUMP = 8'h0D;
  localparam logic [7:0] O_LU   = 8'hC4;
  localparam logic [7:0] O_ABAN = 8'h02;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ex_is_load_i = 1'b0;
  logic [4:0]       ex_rd_i = '0;
  logic [4:0]       id_rs1_i = '0;
  logic [4:0]       id_rs2_i = '0;
  logic             id_rs1_re_i = 1'b0;
  logic             id_rs2_re_i = 1'b0;
  logic             ex_jump_i = 1'b0;
  logic [31:0]      ex_jump_addr_i = '0;
  logic             mem_req_i = 1'b0;
  logic             mem_ready_i = 1'b0;
  logic             hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o;
  logic             flush_if_id_o, flush_id_ex_o, bubble_mem_wb_o, jump_o;
  logic [31:0]      jump_addr_o;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_pending;
  int m_stalled;
  bit m_to;
  int m_sc;
  int m_fc;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
    .ex_jump_i(ex_jump_i), .ex_jump_addr_i(ex_jump_addr_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o),
    .hold_id_ex_o(hold_id_ex_o), .hold_ex_mem_o(hold_ex_mem_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .bubble_mem_wb_o(bubble_mem_wb_o), .jump_o(jump_o),
    .jump_addr_o(jump_addr_o), .mem_timeout_o(mem_timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
            flush_if_id_o, flush_id_ex_o, bubble_mem_wb_o, jump_o};
  endfunction

  function automatic bit model_load_use();
    return ex_is_load_i && (ex_rd_i != 0) &&
           ((id_rs1_re_i && id_rs1_i == ex_rd_i) || (id_rs2_re_i && id_rs2_i == ex_rd_i));
  endfunction

  // The access stays outstanding while the bus is busy; after MEM_TIMEOUT-1 held cycles it is dropped
  function automatic logic [7:0] model_outs();
    bit busy;
    busy = mem_req_i && !mem_ready_i;
    if (!rst_n) return O_NONE;
    if (busy) return (m_pending && m_stalled >= MEM_TIMEOUT - 1) ? O_ABAN : O_MEM;
    if (ex_jump_i) return O_JUMP;
    if (model_load_use()) return O_LU;
    return O_NONE;
  endfunction

  task automatic model_step(input logic [7:0] e);
    if (!rst_n) begin
      m_pending = 0; m_stalled = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_to = (e == O_ABAN);
      if (e == O_MEM) begin
        m_pending = 1; m_stalled++;
      end else begin
        m_pending = 0; m_stalled = 0;
      end
      if (e[7] && m_sc < SAT) m_sc++;
      if (e[0] && m_fc < SAT) m_fc++;
    end
  endtask

  task automatic clear_inputs();
    ex_is_load_i = 0; ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    id_rs1_re_i = 0; id_rs2_re_i = 0; ex_jump_i = 0; ex_jump_addr_i = 0;
    mem_req_i = 0; mem_ready_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    mem_req_i = 1; mem_ready_i = 0; ex_jump_i = 1; ex_jump_addr_i = 32'hDEAD_BEEF;
    ex_is_load_i = 1; ex_rd_i = 5'd3; id_rs1_i = 5'd3; id_rs1_re_i = 1;
    @(posedge clk); #2;
    checks++;
    if (outs() !== O_NONE) begin errors++; $display("FAIL reset_outs got=%h exp=%h", outs(), O_NONE); end
    checks++;
    if (jump_addr_o !== 32'd0) begin errors++; $display("FAIL reset_jump_addr got=%h exp=0", jump_addr_o); end
    checks++;
    if (mem_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout_o); end
    checks++;
    if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_is_load_i = 1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_rs1_re_i = 1;
    @(negedge clk); checks++;
    if (outs() !== O_LU) begin errors++; $display("FAIL lu_rs1 got=%h exp=%h", outs(), O_LU); end
    next_cycle();
    ex_rd_i = 5'd0; id_rs1_i = 5'd0;
    @(negedge clk); checks++;
    if (outs() !== O_NONE) begin errors++; $display("FAIL lu_x0 got=%h exp=%h", outs(), O_NONE); end
    next_cycle();
    ex_rd_i = 5'd9; id_rs1_i = 5'd3; id_rs2_i = 5'd9; id_rs2_re_i = 1;
    @(negedge clk); checks++;
    if (outs() !== O_LU) begin errors++; $display("FAIL lu_rs2 got=%h exp=%h", outs(), O_LU); end
    next_cycle();
    id_rs2_re_i = 0;
    @(negedge clk); checks++;
    if (outs() !== O_NONE) begin errors++; $display("FAIL lu_no_read got=%h exp=%h", outs(), O_NONE); end
    next_cycle();
    id_rs2_re_i = 1; ex_is_load_i = 0;
    @(negedge clk); checks++;
    if (outs() !== O_NONE) begin errors++; $display("FAIL lu_not_load got=%h exp=%h", outs(), O_NONE); end
    next_cycle();
    clear_inputs();
    @(negedge clk); checks++;
    if (stall_cnt_o !== 5'd2) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=2", stall_cnt_o); end
    next_cycle();
  endtask

  task automatic test_jump();
    do_reset();
    ex_jump_i = 1; ex_jump_addr_i = 32'h80;
    ex_is_load_i = 1; ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs1_re_i = 1;
    @(negedge clk); checks++;
    if (outs() !== O_JUMP) begin errors++; $display("FAIL jump_outs got=%h exp=%h", outs(), O_JUMP); end
    checks++;
    if (jump_addr_o !== 32'h80) begin errors++; $display("FAIL jump_addr got=%h exp=80", jump_addr_o); end
    next_cycle();
    clear_inputs();
    @(negedge clk); checks++;
    if (outs() !== O_NONE) begin errors++; $display("FAIL jump_after got=%h exp=%h", outs(), O_NONE); end
    checks++;
    if (flush_cnt_o !== 5'd1 || stall_cnt_o !== 5'd0) begin
      errors++; $display("FAIL jump_counters got=%0d/%0d exp=1/0", flush_cnt_o, stall_cnt_o);
    end
    next_cycle();
  endtask

  task automatic test_wait();
    do_reset();
    mem_req_i = 1; mem_ready_i = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); checks++;
      if (outs() !== O_MEM) begin errors++; $display("FAIL wait_hold[%0d] got=%h exp=%h", c, outs(), O_MEM); end
      next_cycle();
    end
    mem_ready_i = 1;
    @(negedge clk); checks++;
    if (outs() !== O_NONE) begin errors++; $display("FAIL wait_release got=%h exp=%h", outs(), O_NONE); end
    next_cycle();
    clear_inputs();
    @(negedge clk); checks++;
    if (stall_cnt_o !== 5'd3 || mem_timeout_o !== 1'b0) begin
      errors++; $display("FAIL wait_stall_cnt got=%0d to=%b exp=3 to=0", stall_cnt_o, mem_timeout_o);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_i = 1; mem_ready_i = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk); checks++;
      if (outs() !== O_MEM) begin errors++; $display("FAIL to_hold[%0d] got=%h exp=%h", c, outs(), O_MEM); end
      next_cycle();
    end
    @(negedge clk); checks++;
    if (outs() !== O_ABAN || mem_timeout_o !== 1'b0) begin
      errors++; $display("FAIL to_abandon got=%h to=%b exp=%h to=0", outs(), mem_timeout_o, O_ABAN);
    end
    next_cycle();
    mem_req_i = 0;
    @(negedge clk); checks++;
    if (mem_timeout_o !== 1'b1 || outs() !== O_NONE) begin
      errors++; $display("FAIL to_pulse got to=%b outs=%h exp to=1 outs=%h", mem_timeout_o, outs(), O_NONE);
    end
    checks++;
    if (stall_cnt_o !== 5'd15) begin errors++; $display("FAIL to_stall_cnt got=%0d exp=15", stall_cnt_o); end
    next_cycle();
    @(negedge clk); checks++;
    if (mem_timeout_o !== 1'b0) begin errors++; $display("FAIL to_pulse_end got=%b exp=0", mem_timeout_o); end
    next_cycle();
  endtask

  task automatic test_jump_wait();
    do_reset();
    mem_req_i = 1; mem_ready_i = 0; ex_jump_i = 1; ex_jump_addr_i = 32'h0000_1234;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); checks++;
      if (outs() !== O_MEM) begin errors++; $display("FAIL jw_hold[%0d] got=%h exp=%h", c, outs(), O_MEM); end
      next_cycle();
    end
    mem_ready_i = 1;
    @(negedge clk); checks++;
    if (outs() !== O_JUMP || jump_addr_o !== 32'h1234) begin
      errors++; $display("FAIL jw_take got=%h/%h exp=%h/1234", outs(), jump_addr_o, O_JUMP);
    end
    next_cycle();
    clear_inputs();
    @(negedge clk); checks++;
    if (flush_cnt_o !== 5'd1 || stall_cnt_o !== 5'd2) begin
      errors++; $display("FAIL jw_counters got=%0d/%0d exp=1/2", flush_cnt_o, stall_cnt_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    int held;
    do_reset();
    mem_req_i = 1; mem_ready_i = 0;
    for (int c = 0; c < 4; c++) next_cycle();
    #2 rst_n = 0;
    #1 checks++;
    if (outs() !== O_NONE || stall_cnt_o !== '0) begin
      errors++; $display("FAIL rmw_async got=%h cnt=%0d exp=%h cnt=0", outs(), stall_cnt_o, O_NONE);
    end
    next_cycle();
    rst_n = 1;
    held = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (outs() !== O_MEM) break;
      held++;
      next_cycle();
    end
    checks++;
    if (held != MEM_TIMEOUT - 1) begin errors++; $display("FAIL rmw_fresh_wait got=%0d exp=%0d", held, MEM_TIMEOUT - 1); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_jump_i = 1;
    for (int c = 0; c < 40; c++) next_cycle();
    ex_jump_i = 0;
    ex_is_load_i = 1; ex_rd_i = 5'd2; id_rs2_i = 5'd2; id_rs2_re_i = 1;
    for (int c = 0; c < 40; c++) next_cycle();
    clear_inputs();
    @(negedge clk); checks++;
    if (flush_cnt_o !== 5'd31 || stall_cnt_o !== 5'd31) begin
      errors++; $display("FAIL sat_counters got=%0d/%0d exp=31/31", flush_cnt_o, stall_cnt_o);
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic [7:0] e;
    int ready_pct;
    do_reset();
    m_pending = 0; m_stalled = 0; m_to = 0; m_sc = 0; m_fc = 0;
    for (int i = 0; i < 2500; i++) begin
      ready_pct = ((i / 250) % 2 == 1) ? 5 : 60;
      rst_n = ($urandom_range(0, 299) != 0);
      ex_is_load_i = $urandom_range(0, 1);
      ex_rd_i = 5'($urandom_range(0, 7));
      id_rs1_i = 5'($urandom_range(0, 7));
      id_rs2_i = 5'($urandom_range(0, 7));
      id_rs1_re_i = $urandom_range(0, 1);
      id_rs2_re_i = $urandom_range(0, 1);
      ex_jump_i = ($urandom_range(0, 5) == 0);
      ex_jump_addr_i = $urandom;
      mem_req_i = $urandom_range(0, 1);
      mem_ready_i = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      e = model_outs();
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL rnd_outs[%0d] got=%h exp=%h", i, outs(), e); end
      checks++;
      if (jump_addr_o !== (rst_n ? ex_jump_addr_i : 32'd0)) begin
        errors++; $display("FAIL rnd_jump_addr[%0d] got=%h exp=%h", i, jump_addr_o, rst_n ? ex_jump_addr_i : 32'd0);
      end
      checks++;
      if (mem_timeout_o !== (rst_n & m_to)) begin
        errors++; $display("FAIL rnd_timeout[%0d] got=%b exp=%b", i, mem_timeout_o, rst_n & m_to);
      end
      checks++;
      if (stall_cnt_o !== (rst_n ? CNT_W'(m_sc) : '0) || flush_cnt_o !== (rst_n ? CNT_W'(m_fc) : '0)) begin
        errors++; $display("FAIL rnd_counters[%0d] got=%0d/%0d exp=%0d/%0d", i, stall_cnt_o, flush_cnt_o,
                           rst_n ? m_sc : 0, rst_n ? m_fc : 0);
      end
      @(posedge clk);
      model_step(e);
      #1;
    end
    rst_n = 1;
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_jump();
    test_wait();
    test_timeout();
    test_jump_wait();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
